// File: rtl/tdc_readout.sv
// TDC response RAM reader: sweeps addresses 0..T-1, one word in flight,
// and streams popcount plus thermometer-bubble flag per word.
module tdc_readout #(
  parameter int N          = 256,
  parameter int T          = 512,
  parameter int RD_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   rd_en,
  output logic [$clog2(T)-1:0]   rd_addr,
  input  logic [N-1:0]           rd_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(T)-1:0]   out_addr,
  output logic [$clog2(N+1)-1:0] out_count,
  output logic                   out_bubble,
  output logic                   out_last
);

  localparam int AW = $clog2(T);
  localparam int CW = $clog2(N+1);
  localparam logic [AW-1:0] LAST = AW'(T - 1);
  localparam logic [2:0] LAT_M1 = 3'(RD_LATENCY - 1);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] READ = 3'd1;
  localparam logic [2:0] WAIT = 3'd2;
  localparam logic [2:0] CALC = 3'd3;
  localparam logic [2:0] PRES = 3'd4;
  localparam logic [2:0] DONE = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] oaddr_q, oaddr_d;
  logic [2:0]    wcnt_q, wcnt_d;
  logic [N-1:0]  word_q, word_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] pop;
  logic          bubble_w;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          valid_q, valid_d;
  logic          bub_q, bub_d;
  logic          last_q, last_d;

  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) begin
      pop = pop + CW'(word_q[i]);
    end
  end

  // a 0 directly below a 1 breaks the thermometer code
  assign bubble_w = |(~word_q[N-2:0] & word_q[N-1:1]);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    oaddr_d = oaddr_q;
    wcnt_d  = wcnt_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    valid_d = valid_q;
    bub_d   = bub_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = READ;
          addr_d  = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      READ: begin
        wcnt_d  = LAT_M1;
        state_d = WAIT;
      end
      WAIT: begin
        if (wcnt_q == 3'd0) begin
          word_d  = rd_data;
          state_d = CALC;
        end else begin
          wcnt_d = wcnt_q - 3'd1;
        end
      end
      CALC: begin
        cnt_d   = pop;
        bub_d   = bubble_w;
        oaddr_d = addr_q;
        last_d  = (addr_q == LAST);
        valid_d = 1'b1;
        state_d = PRES;
      end
      PRES: begin
        if (out_ready) begin
          valid_d = 1'b0;
          if (addr_q == LAST) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            addr_d  = addr_q + AW'(1);
            state_d = READ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      oaddr_q <= '0;
      wcnt_q  <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      bub_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      oaddr_q <= oaddr_d;
      wcnt_q  <= wcnt_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      bub_q   <= bub_d;
      last_q  <= last_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign rd_en      = (state_q == READ);
  assign rd_addr    = addr_q;
  assign out_valid  = valid_q;
  assign out_addr   = oaddr_q;
  assign out_count  = cnt_q;
  assign out_bubble = bub_q;
  assign out_last   = last_q;

endmodule
